// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32 immediate decoder feeding a DEPTH-entry valid/ready output buffer,
// with a saturating counter of accepted illegal-opcode words.
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  logic [31:0]      dec_imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_illegal;

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [2:0]       fmt_mem_q [DEPTH];
  logic             ill_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic push;
  logic pop;

  // All formats sign-extend from ir[31]; the 32-bit result is widened the same way.
  always_comb begin
    dec_imm32   = 32'd0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (in_ir[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_ir[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_imm = XLEN'($signed(dec_imm32));

  // Full blocks input even when the head is being popped this cycle.
  assign in_ready  = (count_q < FULL_OCC);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_imm     = imm_mem_q[rd_ptr_q];
  assign out_fmt     = fmt_mem_q[rd_ptr_q];
  assign out_illegal = ill_mem_q[rd_ptr_q];
  assign illegal_cnt = illegal_cnt_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
    if (cnt_clr) begin
      illegal_cnt_d = '0;
    end else if (push && dec_illegal && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem_q[wr_ptr_q] <= dec_imm;
      fmt_mem_q[wr_ptr_q] <= dec_fmt;
      ill_mem_q[wr_ptr_q] <= dec_illegal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives a 32-bit/CNT_W=16 and a 64-bit/CNT_W=2 instance in lockstep;
// a negedge monitor scores head outputs against a queue of hand-computed results.
`default_nettype none

module tb_imm_gen_pipe;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_ir;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [15:0] cnt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [1:0]  cnt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(16)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_ir(in_ir),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32), .cnt_clr(cnt_clr),
    .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .CNT_W(2)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_ir(in_ir),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .cnt_clr(cnt_clr),
    .illegal_cnt(cnt64)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb_q[$];
  vec_t exp_cur;
  vec_t vecs[15];
  vec_t e;
  logic last_acc = 1'b0;
  int   m32 = 0;
  int   m64 = 0;
  int   sz;
  logic hold = 1'b0;
  logic [31:0] h_imm32;
  logic [63:0] h_imm64;
  logic [2:0]  h_fmt;
  logic        h_ill;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: occupancy model, ordered pops, hold stability, illegal counters.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m32      = 0;
      m64      = 0;
      last_acc = 1'b0;
      hold     = 1'b0;
    end else begin
      sz = sb_q.size();
      chk("in_ready32", 64'(in_ready32), 64'(sz < DEPTH));
      chk("in_ready64", 64'(in_ready64), 64'(sz < DEPTH));
      chk("out_valid32", 64'(out_valid32), 64'(sz > 0));
      chk("out_valid64", 64'(out_valid64), 64'(sz > 0));
      chk("illegal_cnt32", 64'(cnt32), 64'(m32));
      chk("illegal_cnt64", 64'(cnt64), 64'(m64));
      if (hold && out_valid32) begin
        chk("hold_imm32", 64'(out_imm32), 64'(h_imm32));
        chk("hold_imm64", out_imm64, h_imm64);
        chk("hold_fmt", 64'(out_fmt32), 64'(h_fmt));
        chk("hold_ill", 64'(out_illegal32), 64'(h_ill));
      end
      if (out_valid32 && out_ready && sz > 0) begin
        e = sb_q.pop_front();
        chk("imm32", 64'(out_imm32), 64'(e.imm[31:0]));
        chk("imm64", out_imm64, e.imm);
        chk("fmt32", 64'(out_fmt32), 64'(e.fmt));
        chk("fmt64", 64'(out_fmt64), 64'(e.fmt));
        chk("illegal32", 64'(out_illegal32), 64'(e.ill));
        chk("illegal64", 64'(out_illegal64), 64'(e.ill));
      end
      hold    = out_valid32 && !out_ready;
      h_imm32 = out_imm32;
      h_imm64 = out_imm64;
      h_fmt   = out_fmt32;
      h_ill   = out_illegal32;
      last_acc = in_valid && (sz < DEPTH);
      if (last_acc) sb_q.push_back(exp_cur);
      if (cnt_clr) begin
        m32 = 0;
        m64 = 0;
      end else if (last_acc && exp_cur.ill) begin
        if (m32 < 65535) m32++;
        if (m64 < 3) m64++;
      end
    end
  end

  // Called at posedge+1; leaves in_valid high so back-to-back pushes stream.
  task automatic push_word(input vec_t v);
    int tries;
    in_valid = 1'b1;
    in_ir    = v.ir;
    exp_cur  = v;
    tries    = 0;
    do begin
      @(posedge clk);
      tries++;
    end while (!last_acc && tries < 40);
    #1;
    if (!last_acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: ir %h not accepted within 40 cycles", v.ir);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int tries;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tries     = 0;
    while (sb_q.size() != 0 && tries < 40) begin
      @(posedge clk);
      tries++;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries still expected", sb_q.size());
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ir, input logic [63:0] imm,
                              input logic [2:0] fmt, input logic ill);
    vec_t v;
    v.ir = ir; v.imm = imm; v.fmt = fmt; v.ill = ill;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0);
    vecs[1]  = mk(32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0);
    vecs[2]  = mk(32'hFE000CE3, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0);
    vecs[3]  = mk(32'h123450B7, 64'h00000000_12345000, 3'd4, 1'b0);
    vecs[4]  = mk(32'hFFDFF06F, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0);
    vecs[5]  = mk(32'h800000B7, 64'hFFFFFFFF_80000000, 3'd4, 1'b0);
    vecs[6]  = mk(32'h00812083, 64'h00000000_00000008, 3'd1, 1'b0);
    vecs[7]  = mk(32'h00008067, 64'h00000000_00000000, 3'd1, 1'b0);
    vecs[8]  = mk(32'h7FF00013, 64'h00000000_000007FF, 3'd1, 1'b0);
    vecs[9]  = mk(32'h00112423, 64'h00000000_00000008, 3'd2, 1'b0);
    vecs[10] = mk(32'h00208463, 64'h00000000_00000008, 3'd3, 1'b0);
    vecs[11] = mk(32'h00001017, 64'h00000000_00001000, 3'd4, 1'b0);
    vecs[12] = mk(32'h008000EF, 64'h00000000_00000008, 3'd5, 1'b0);
    vecs[13] = mk(32'h0000007F, 64'h00000000_00000000, 3'd0, 1'b1);
    vecs[14] = mk(32'hFFFFFFFF, 64'h00000000_00000000, 3'd0, 1'b1);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ir     = 32'h0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    exp_cur   = vecs[0];
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid32), 64'd0);
    chk("reset_in_ready", 64'(in_ready32), 64'd1);
    chk("reset_cnt", 64'(cnt32), 64'd0);
    @(posedge clk);
    #1;

    // Streaming with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i <= 12; i++) push_word(vecs[i]);
    drain();

    // Backpressure: two accepts fill the buffer, the third waits for a free slot.
    out_ready = 1'b0;
    push_word(vecs[0]);
    push_word(vecs[1]);
    fork
      push_word(vecs[2]);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal words and the counter.
    for (int i = 0; i < 3; i++) push_word(vecs[13]);
    idle(1);
    @(negedge clk);
    chk("cnt32_after3", 64'(cnt32), 64'd3);
    chk("cnt64_after3", 64'(cnt64), 64'd3);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    push_word(vecs[13]);
    cnt_clr = 1'b0;
    idle(1);
    @(negedge clk);
    chk("cnt32_clr_wins", 64'(cnt32), 64'd0);
    chk("cnt64_clr_wins", 64'(cnt64), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push_word(vecs[13 + (i % 2)]);
    idle(1);
    @(negedge clk);
    chk("cnt32_after5", 64'(cnt32), 64'd5);
    chk("cnt64_saturated", 64'(cnt64), 64'd3);
    @(posedge clk);
    #1;
    drain();

    // Reset with two buffered entries and a push attempt in the reset cycle.
    out_ready = 1'b0;
    push_word(vecs[3]);
    push_word(vecs[4]);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_ir    = vecs[5].ir;
    exp_cur  = vecs[5];
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid32), 64'd0);
    chk("midrst_in_ready", 64'(in_ready32), 64'd1);
    chk("midrst_cnt32", 64'(cnt32), 64'd0);
    chk("midrst_cnt64", 64'(cnt64), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(4);
    push_word(vecs[8]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
